// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares the single-port 1K x 32 instruction memory between the program
//   loader (write-only) and the instruction fetch controller (read-only).
//   Each side gets an exclusive grant that it keeps until it releases.
//   The owner's strobes are muxed onto the memory port. Read data goes from
//   the memory straight to the fetch side and does not pass through here.
//
//   Optional feature: define IMEM_ARB_TIMEOUT_EN to enable the hold counter.
//   With it, an owner that keeps the grant for TIMEOUT_CYCLES cycles while
//   the other side waits is forced off. Without it, arb_timeout is tied 0 and
//   a grant is held for as long as the owner wants it.
//
//   Request/grant handshake (both sides):
//     - The requester drives req_b low and holds it low.
//     - gnt_b goes low the cycle after req_b is sampled low.
//     - The requester may pulse ceb only while it sees gnt_b low.
//     - Raising req_b releases the grant. One DRAIN cycle with no owner
//       follows, then the arbiter returns to IDLE.
//
// Ports
//   clk, resetB                  clock, asynchronous active-low reset
//   ld_req_b / ld_gnt_b          loader request / grant (active low)
//   ld_ceb, ld_web, ld_addr,
//   ld_wdata                     loader memory strobes
//   fe_req_b / fe_gnt_b          fetch request / grant (active low)
//   fe_ceb, fe_web, fe_addr      fetch memory strobes
//   imem_ceb, imem_web,
//   imem_addr, imem_wdata        memory port
//   arb_owner                    01 = loader, 10 = fetch, 00 = none
//   arb_timeout                  one-cycle pulse on a forced release
//   dbg_state                    FSM state (IDLE=0, GNT_LD=1, GNT_FE=2, DRAIN=3)
module imem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic        clk,
  input  logic        resetB,
  input  logic        ld_req_b,
  output logic        ld_gnt_b,
  input  logic        ld_ceb,
  input  logic        ld_web,
  input  logic [9:0]  ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic        fe_req_b,
  output logic        fe_gnt_b,
  input  logic        fe_ceb,
  input  logic        fe_web,
  input  logic [9:0]  fe_addr,
  output logic        imem_ceb,
  output logic        imem_web,
  output logic [9:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic [1:0]  arb_owner,
  output logic        arb_timeout,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_LD = 2'd1,
    GNT_FE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   last_fe_q, last_fe_d;  // 1: fetch was the most recent owner
  logic   hold_expired;          // owner has used up its hold budget

`ifdef IMEM_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] HOLD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] hold_cnt_q;
  logic            other_wait;
  logic            forced_rel;

  always_comb begin
    other_wait   = ((state_q == GNT_LD) && !fe_req_b) ||
                   ((state_q == GNT_FE) && !ld_req_b);
    hold_expired = other_wait && (hold_cnt_q == HOLD_LAST);
    // Only a pulse when the owner still wanted the grant. A voluntary release
    // in the same cycle is not a timeout.
    forced_rel   = hold_expired &&
                   (((state_q == GNT_LD) && !ld_req_b) ||
                    ((state_q == GNT_FE) && !fe_req_b));
  end

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      hold_cnt_q  <= '0;
      arb_timeout <= 1'b0;
    end else begin
      arb_timeout <= forced_rel;
      if (state_d == IDLE)
        hold_cnt_q <= '0;
      else if (other_wait && !hold_expired)
        hold_cnt_q <= hold_cnt_q + 1'b1;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign arb_timeout  = 1'b0;
`endif

  // Next-state logic. A tie in IDLE goes to the side that did not own last.
  always_comb begin
    state_d   = state_q;
    last_fe_d = last_fe_q;
    case (state_q)
      IDLE: begin
        if (!ld_req_b && (fe_req_b || last_fe_q)) begin
          state_d   = GNT_LD;
          last_fe_d = 1'b0;
        end else if (!fe_req_b) begin
          state_d   = GNT_FE;
          last_fe_d = 1'b1;
        end
      end
      GNT_LD: if (ld_req_b || hold_expired) state_d = DRAIN;
      GNT_FE: if (fe_req_b || hold_expired) state_d = DRAIN;
      DRAIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The grant and owner outputs are flops loaded from the next state.
  // This keeps them glitch-free and aligned with the state register.
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state_q   <= IDLE;
      last_fe_q <= 1'b1;
      ld_gnt_b  <= 1'b1;
      fe_gnt_b  <= 1'b1;
      arb_owner <= 2'b00;
    end else begin
      state_q   <= state_d;
      last_fe_q <= last_fe_d;
      ld_gnt_b  <= (state_d != GNT_LD);
      fe_gnt_b  <= (state_d != GNT_FE);
      arb_owner <= {state_d == GNT_FE, state_d == GNT_LD};
    end
  end

  // Memory mux, driven from the registered state only.
  always_comb begin
    imem_ceb   = 1'b1;
    imem_web   = 1'b1;
    imem_addr  = '0;
    imem_wdata = '0;
    case (state_q)
      GNT_LD: begin
        imem_ceb   = ld_ceb;
        imem_web   = ld_web;
        imem_addr  = ld_addr;
        imem_wdata = ld_wdata;
      end
      GNT_FE: begin
        imem_ceb  = fe_ceb;
        imem_web  = fe_web | 1'b1;  // fetch is read-only; its web is overridden
        imem_addr = fe_addr;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  logic        clk;
  logic        resetB;
  logic        ld_req_b, ld_gnt_b, ld_ceb, ld_web;
  logic [9:0]  ld_addr;
  logic [31:0] ld_wdata;
  logic        fe_req_b, fe_gnt_b, fe_ceb, fe_web;
  logic [9:0]  fe_addr;
  logic        imem_ceb, imem_web;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0]  arb_owner;
  logic        arb_timeout;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  imem_arbiter #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
    .clk(clk), .resetB(resetB),
    .ld_req_b(ld_req_b), .ld_gnt_b(ld_gnt_b), .ld_ceb(ld_ceb), .ld_web(ld_web),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .fe_req_b(fe_req_b), .fe_gnt_b(fe_gnt_b), .fe_ceb(fe_ceb), .fe_web(fe_web),
    .fe_addr(fe_addr),
    .imem_ceb(imem_ceb), .imem_web(imem_web), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .arb_owner(arb_owner), .arb_timeout(arb_timeout),
    .dbg_state(dbg_state)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- 1K x 32 memory macro model ----
  logic [31:0] mem [0:1023];
  logic [31:0] mem_rdata;
  always @(posedge clk) begin
    if (!imem_ceb) begin
      if (!imem_web) mem[imem_addr] <= imem_wdata;
      else           mem_rdata      <= mem[imem_addr];
    end
  end

  // ---- checking ----
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until the given grant goes low, bounded.
  task automatic wait_gnt(input bit fe_side, output int n);
    n = 0;
    while (((fe_side ? fe_gnt_b : ld_gnt_b) == 1'b1) && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ld_gnt"},  {31'd0, ld_gnt_b},    32'd1);
    check_eq({tag, "_fe_gnt"},  {31'd0, fe_gnt_b},    32'd1);
    check_eq({tag, "_ceb"},     {31'd0, imem_ceb},    32'd1);
    check_eq({tag, "_web"},     {31'd0, imem_web},    32'd1);
    check_eq({tag, "_addr"},    {22'd0, imem_addr},   32'd0);
    check_eq({tag, "_wdata"},   imem_wdata,           32'd0);
    check_eq({tag, "_owner"},   {30'd0, arb_owner},   32'd0);
    check_eq({tag, "_timeout"}, {31'd0, arb_timeout}, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] exp_q [$];
    logic saw_to, saw_rel;

    resetB = 1'b1;
    ld_req_b = 1'b1; ld_ceb = 1'b1; ld_web = 1'b1; ld_addr = '0; ld_wdata = '0;
    fe_req_b = 1'b1; fe_ceb = 1'b1; fe_web = 1'b1; fe_addr = '0;
    #2 resetB = 1'b0;
    #1 check_reset_outputs("rst");
    tick(); tick();
    resetB = 1'b1;
    tick();

    // Tie from reset: loader wins. Fetch pokes at 0x3FF while the loader writes.
    ld_req_b = 1'b0; fe_req_b = 1'b0;
    tick();
    check_eq("tie0_ld_gnt", {31'd0, ld_gnt_b}, 32'd0);
    check_eq("tie0_fe_gnt", {31'd0, fe_gnt_b}, 32'd1);
    check_eq("tie0_owner",  {30'd0, arb_owner}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      ld_ceb = 1'b0; ld_web = 1'b0; ld_addr = 10'(i); ld_wdata = 32'hDEADBEEF + i;
      fe_ceb = 1'b0; fe_addr = 10'h3FF;
      exp_q.push_back(32'hDEADBEEF + i);
      #1;
      check_eq("wr_ceb",   {31'd0, imem_ceb},  32'd0);
      check_eq("wr_web",   {31'd0, imem_web},  32'd0);
      check_eq("wr_addr",  {22'd0, imem_addr}, i);
      check_eq("wr_wdata", imem_wdata,         32'hDEADBEEF + i);
      tick();
    end
    ld_ceb = 1'b1; ld_web = 1'b1; fe_ceb = 1'b1;
    ld_req_b = 1'b1;
    wait_gnt(1'b1, n);
    check_eq("fe_gnt_latency", n, 32'd3);
    check_eq("fe_owner", {30'd0, arb_owner}, 32'd2);
    for (int i = 0; i < 4; i++) check_eq("mem_content", mem[i], exp_q[i]);

    // Fetch reads back with fe_web low; the memory must still see a read.
    for (int i = 0; i < 4; i++) begin
      fe_ceb = 1'b0; fe_web = 1'b0; fe_addr = 10'(i);
      #1;
      check_eq("rd_web",   {31'd0, imem_web},  32'd1);
      check_eq("rd_wdata", imem_wdata,         32'd0);
      check_eq("rd_addr",  {22'd0, imem_addr}, i);
      tick();
      check_eq("rd_data", mem_rdata, exp_q.pop_front());
    end
    fe_ceb = 1'b1; fe_web = 1'b1;

    // Loader waits while fetch keeps its grant.
    ld_req_b = 1'b0;
`ifdef IMEM_ARB_TIMEOUT_EN
    repeat (7) tick();
    check_eq("to_hold_fe_gnt", {31'd0, fe_gnt_b},    32'd0);
    check_eq("to_hold_pulse",  {31'd0, arb_timeout}, 32'd0);
    tick();
    check_eq("to_fe_gnt", {31'd0, fe_gnt_b},    32'd1);
    check_eq("to_pulse",  {31'd0, arb_timeout}, 32'd1);
    tick();
    check_eq("to_pulse_end", {31'd0, arb_timeout}, 32'd0);
    check_eq("to_drain_ld",  {31'd0, ld_gnt_b},    32'd1);
    tick();
    check_eq("to_ld_gnt",    {31'd0, ld_gnt_b}, 32'd0);
    check_eq("to_no_regrant", {31'd0, fe_gnt_b}, 32'd1);
    fe_req_b = 1'b1;
`else
    saw_to = 1'b0; saw_rel = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      saw_to  = saw_to | arb_timeout;
      saw_rel = saw_rel | fe_gnt_b;
    end
    check_eq("hold_fe_kept",   {31'd0, saw_rel}, 32'd0);
    check_eq("hold_no_pulse",  {31'd0, saw_to},  32'd0);
    check_eq("hold_ld_waits",  {31'd0, ld_gnt_b}, 32'd1);
    fe_req_b = 1'b1;
    wait_gnt(1'b0, n);
    check_eq("ld_gnt_latency", n, 32'd3);
`endif
    check_eq("ld_owner", {30'd0, arb_owner}, 32'd1);

    // A fetch request raised and dropped during DRAIN is never granted.
    ld_req_b = 1'b1;
    tick();
    fe_req_b = 1'b0;
    tick();
    fe_req_b = 1'b1;
    tick();
    check_eq("withdrawn_fe_gnt", {31'd0, fe_gnt_b},  32'd1);
    check_eq("withdrawn_owner",  {30'd0, arb_owner}, 32'd0);

    // Alternation: loader owned last, so fetch wins this tie, and loader the next.
    ld_req_b = 1'b0; fe_req_b = 1'b0;
    tick();
    check_eq("tie1_fe_gnt", {31'd0, fe_gnt_b}, 32'd0);
    check_eq("tie1_ld_gnt", {31'd0, ld_gnt_b}, 32'd1);
    ld_req_b = 1'b1; fe_req_b = 1'b1;
    tick(); tick();
    ld_req_b = 1'b0; fe_req_b = 1'b0;
    tick();
    check_eq("tie2_ld_gnt", {31'd0, ld_gnt_b}, 32'd0);
    check_eq("tie2_fe_gnt", {31'd0, fe_gnt_b}, 32'd1);

    // Reset in the middle of a loader write clears everything without an edge.
    ld_ceb = 1'b0; ld_web = 1'b0; ld_addr = 10'd5; ld_wdata = 32'h12345678;
    #1 check_eq("pre_rst_ceb", {31'd0, imem_ceb}, 32'd0);
    #1 resetB = 1'b0;
    #1 check_reset_outputs("mid_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
